// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer.
//   state_t       controller FSM states
//   DEFAULT_*     default widths and feedback mask (x^8+x^6+x^5+x^4+1, period 255)
//   lfsr_feedback helper: XOR of the tapped bits of a state word
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_NBITS = 8;
    localparam int unsigned DEFAULT_CNT_W = 16;
    localparam logic [7:0]  DEFAULT_TAPS  = 8'hB8;

    // Feedback bit for an LFSR of up to 64 bits; callers zero-extend q and taps.
    function automatic logic lfsr_feedback(input logic [63:0] q, input logic [63:0] taps);
        return ^(q & taps);
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational Fibonacci LFSR step: shift left, feedback into the LSB.
//   q       in   NBITS  current state
//   q_next  out  NBITS  step(q) = {q[NBITS-2:0], ^(q & TAPS)}
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned      NBITS = DEFAULT_NBITS,
    parameter logic [NBITS-1:0] TAPS  = NBITS'(DEFAULT_TAPS)
) (
    input  logic [NBITS-1:0] q,
    output logic [NBITS-1:0] q_next
);

    logic fb;

    always_comb begin
        fb     = lfsr_feedback(64'(q), 64'(TAPS));
        q_next = {q[NBITS-2:0], fb};
    end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for an external LFSR state register. Accepts a seed and a step count,
// loads the seed, drives N shifts through reg_en/reg_d, then offers the result on a
// valid/ready output. The state itself lives in the external register (reg_q).
//   clk, rst   clock, synchronous active-high reset
//   req_*      request handshake: seed and number of shifts (0 allowed)
//   reg_en/d   write enable and next value for the external state register
//   reg_q      current value of the external state register
//   out_*      result handshake; out_zfix flags a zero seed replaced by 1
//   busy       controller is not idle
module lfsr_seq_ctrl
    import lfsr_pkg::*;
#(
    parameter int unsigned      NBITS = DEFAULT_NBITS,
    parameter logic [NBITS-1:0] TAPS  = NBITS'(DEFAULT_TAPS),
    parameter int unsigned      CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_seed,
    input  logic [CNT_W-1:0] req_n,
    output logic             reg_en,
    output logic [NBITS-1:0] reg_d,
    input  logic [NBITS-1:0] reg_q,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_data,
    output logic             out_zfix,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zfix_q, zfix_d;
    logic [NBITS-1:0] step_q;

    lfsr_next #(
        .NBITS (NBITS),
        .TAPS  (TAPS)
    ) u_next (
        .q      (reg_q),
        .q_next (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            zfix_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zfix_q  <= zfix_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        zfix_d   = zfix_q;
        req_rdy  = 1'b0;
        reg_en   = 1'b0;
        reg_d    = '0;
        out_val  = 1'b0;
        out_data = '0;
        out_zfix = 1'b0;
        busy     = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    reg_en = 1'b1;
                    // All-zero is the LFSR's lock-up state; substitute 1 and flag it.
                    if (req_seed == '0) begin
                        reg_d  = NBITS'(1);
                        zfix_d = 1'b1;
                    end else begin
                        reg_d  = req_seed;
                        zfix_d = 1'b0;
                    end
                    cnt_d   = req_n;
                    state_d = (req_n == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                reg_en = 1'b1;
                reg_d  = step_q;
                cnt_d  = cnt_q - CNT_W'(1);
                // RUN is only entered with cnt >= 1, so the count never wraps.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_val  = 1'b1;
                out_data = reg_q;
                out_zfix = zfix_q;
                if (out_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
